// File: rtl/output_sample_fifo_pkg.sv
// ============================================================================
// Module   : output_sample_fifo_pkg
// Brief    : Shared defaults for the wavelet output sample FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package output_sample_fifo_pkg;

    localparam int SUM_TRUNCATION_DEFAULT = 8;
    localparam int DEPTH_LOG2_DEFAULT     = 4;
    localparam int DECIM_CNT_WIDTH        = 8;

endpackage

`default_nettype wire

// File: rtl/output_sample_fifo_mem.sv
// ============================================================================
// Module   : output_sample_fifo_mem
// Brief    : Sample storage, one synchronous write port and one async read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module output_sample_fifo_mem
    import output_sample_fifo_pkg::*;
#(
    parameter int WIDTH      = SUM_TRUNCATION_DEFAULT,
    parameter int ADDR_WIDTH = DEPTH_LOG2_DEFAULT
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    // Storage is intentionally not reset; the FIFO masks its head while empty.
    logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/output_sample_fifo.sv
// ============================================================================
// Module   : output_sample_fifo
// Brief    : FWFT FIFO buffering multiplexed wavelet samples for a ready/valid
//            consumer with sticky drop flag. Optional decimation: WAVELET_FIFO_DECIMATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module output_sample_fifo
    import output_sample_fifo_pkg::*;
#(
    parameter int SUM_TRUNCATION = SUM_TRUNCATION_DEFAULT,
    parameter int DEPTH_LOG2     = DEPTH_LOG2_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_sample_strobe,
    input  logic [SUM_TRUNCATION-1:0] i_multiplexed_wavelet_out,
    input  logic                      i_read_ready,
    input  logic                      i_clear_overflow,
`ifdef WAVELET_FIFO_DECIMATE_EN
    input  logic [DECIM_CNT_WIDTH-1:0] i_decimate_ratio,
`endif
    output logic [SUM_TRUNCATION-1:0] o_data,
    output logic                      o_valid,
    output logic [DEPTH_LOG2:0]       o_fill_level,
    output logic                      o_overflow
);

    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    logic [DEPTH_LOG2:0]         wr_ptr;
    logic [DEPTH_LOG2:0]         rd_ptr;
    logic [DEPTH_LOG2:0]         fill_level;
    logic                        overflow;
    logic                        empty;
    logic                        full;
    logic                        keep;
    logic                        push;
    logic                        pop;
    logic                        drop;
    logic [SUM_TRUNCATION-1:0]   head_data;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

    assign pop  = !empty && i_read_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the sample.
    assign push = i_sample_strobe && keep && (!full || pop);
    assign drop = i_sample_strobe && keep && full && !pop;

`ifdef WAVELET_FIFO_DECIMATE_EN
    localparam logic [DECIM_CNT_WIDTH-1:0] DECIM_ONE = 1;

    logic [DECIM_CNT_WIDTH-1:0] decim_cnt;
    logic [DECIM_CNT_WIDTH-1:0] decim_ratio;
    logic [DECIM_CNT_WIDTH-1:0] ratio_eff;

    assign keep = (decim_cnt == '0);
    // A new ratio is only sampled at the start of a decimation period.
    assign ratio_eff = keep ? i_decimate_ratio : decim_ratio;

    always_ff @(posedge clk) begin
        if (rst) begin
            decim_cnt   <= '0;
            decim_ratio <= '0;
        end else if (i_sample_strobe) begin
            if (keep) begin
                decim_ratio <= i_decimate_ratio;
            end
            if ((ratio_eff <= DECIM_ONE) || (decim_cnt >= ratio_eff - DECIM_ONE)) begin
                decim_cnt <= '0;
            end else begin
                decim_cnt <= decim_cnt + DECIM_ONE;
            end
        end
    end
`else
    assign keep = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   fill_level <= fill_level + PTR_ONE;
                2'b01:   fill_level <= fill_level - PTR_ONE;
                default: fill_level <= fill_level;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (i_clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    output_sample_fifo_mem #(
        .WIDTH      (SUM_TRUNCATION),
        .ADDR_WIDTH (DEPTH_LOG2)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr[DEPTH_LOG2-1:0]),
        .wr_data (i_multiplexed_wavelet_out),
        .rd_addr (rd_ptr[DEPTH_LOG2-1:0]),
        .rd_data (head_data)
    );

    assign o_valid      = !empty;
    assign o_data       = empty ? '0 : head_data;
    assign o_fill_level = fill_level;
    assign o_overflow   = overflow;

endmodule

`default_nettype wire
